// File: rtl/net_pkg.sv
// Shared packet format and sizing helpers for the photonic switch network.
// Transmitters and receivers both build on packet_t.
`ifndef PORTS
`define PORTS 4
`endif

package net_pkg;

    // Ceiling log2, never less than 1 so single-port builds still get a field.
    function automatic int log2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int NUM_PORTS = `PORTS;
    localparam int SRC_W     = log2(NUM_PORTS);
    localparam int SEQ_W     = 8;
    localparam int DATA_W    = 32;
    localparam int TS_W      = 16;

    typedef struct packed {
        logic              valid;
        logic [SRC_W-1:0]  source;
        logic [SRC_W-1:0]  dest;
        logic [SEQ_W-1:0]  seq;
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   timestamp;
    } packet_t;

endpackage

// File: rtl/fifo_sync.sv
// Show-ahead synchronous FIFO: head entry is visible on rd_data straight from storage.
// A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign occupancy = count;
    assign do_rd     = rd_en && !empty;
    assign do_wr     = wr_en && (!full || do_rd);
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_simple.sv
// Per-port receiver: registers switch output, filters misroutes, tracks per-source
// sequence continuity, buffers good flits and keeps saturating statistics counters.
module rx_simple
    import net_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int PORTS      = `PORTS,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  packet_t                       flit_in,
    output packet_t                       dout,
    input  logic                          ready,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              misroute_cnt,
    output logic [CNT_W-1:0]              seq_err_cnt,
    output logic                          overflow
);

    localparam logic [SRC_W-1:0] PORT_SEL = SRC_W'(PORT_ID);

    packet_t                         in_r;
    packet_t                         head;
    logic [PORTS-1:0][SEQ_W-1:0]     exp_seq;
    logic                            misroute;
    logic                            accept;
    logic                            seq_bad;
    logic                            drop;
    logic                            fifo_full;
    logic                            fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_r <= '0;
        else     in_r <= flit_in;
    end

    always_comb begin
        misroute = in_r.valid && (in_r.dest != PORT_SEL);
        accept   = in_r.valid && !misroute;
        seq_bad  = accept && (in_r.seq != exp_seq[in_r.source]);
        // A full FIFO is always non-empty, so ready alone tells us a slot frees up.
        drop     = accept && fifo_full && !ready;
    end

    // Both the in-order and resync cases leave the expectation at seq+1.
    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_seq
            logic [SEQ_W-1:0] exp_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    exp_q <= '0;
                else if (accept && (in_r.source == SRC_W'(gi)))
                    exp_q <= in_r.seq + 1'b1;
            end
            assign exp_seq[gi] = exp_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt     <= '0;
            misroute_cnt <= '0;
            seq_err_cnt  <= '0;
            overflow     <= 1'b0;
        end else begin
            if (misroute && (misroute_cnt != '1)) misroute_cnt <= misroute_cnt + 1'b1;
            if (seq_bad && (seq_err_cnt != '1))   seq_err_cnt  <= seq_err_cnt + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    fifo_sync #(
        .WIDTH ($bits(packet_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_data   (in_r),
        .rd_en     (ready),
        .rd_data   (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    always_comb begin
        dout       = head;
        dout.valid = !fifo_empty;
    end

    assign empty = fifo_empty;

endmodule

// File: tb/tb_rx_simple.sv
// Bench for rx_simple: directed scenarios plus random traffic against a queue-based
// reference model of the receiver's classification, buffering and statistics.
module tb_rx_simple;
    import net_pkg::*;

    localparam int PORT_ID = 2;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    packet_t               flit_in = '0;
    packet_t               dout;
    logic                  ready = 1'b0;
    logic                  empty;
    logic [3:0]            occupancy;
    logic [CNT_W-1:0]      drop_cnt;
    logic [CNT_W-1:0]      misroute_cnt;
    logic [CNT_W-1:0]      seq_err_cnt;
    logic                  overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    packet_t          mq[$];
    logic [SEQ_W-1:0] m_exp [NUM_PORTS];
    int               m_drop, m_mis, m_seq;
    bit               m_ovf;
    packet_t          m_inr;

    rx_simple #(
        .PORT_ID    (PORT_ID),
        .PORTS      (NUM_PORTS),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in      (flit_in),
        .dout         (dout),
        .ready        (ready),
        .empty        (empty),
        .occupancy    (occupancy),
        .drop_cnt     (drop_cnt),
        .misroute_cnt (misroute_cnt),
        .seq_err_cnt  (seq_err_cnt),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic packet_t mk(input int src, input int dst, input int sq);
        packet_t p;
        p.valid     = 1'b1;
        p.source    = SRC_W'(src);
        p.dest      = SRC_W'(dst);
        p.seq       = SEQ_W'(sq);
        p.data      = DATA_W'($urandom);
        p.timestamp = TS_W'($urandom);
        return p;
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic mreset();
        mq.delete();
        for (int i = 0; i < NUM_PORTS; i++) m_exp[i] = '0;
        m_drop = 0; m_mis = 0; m_seq = 0; m_ovf = 0;
        m_inr = '0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
    task automatic cycle(input packet_t f, input bit r);
        int sz;
        bit popped;
        flit_in = f;
        ready   = r;
        @(posedge clk);
        sz = mq.size();
        popped = 0;
        if (r && sz > 0) begin
            void'(mq.pop_front());
            popped = 1;
        end
        if (m_inr.valid) begin
            if (int'(m_inr.dest) != PORT_ID) begin
                m_mis = sat(m_mis);
            end else begin
                if (m_inr.seq != m_exp[m_inr.source]) m_seq = sat(m_seq);
                m_exp[m_inr.source] = m_inr.seq + 8'd1;
                if (sz < DEPTH || popped) mq.push_back(m_inr);
                else begin
                    m_drop = sat(m_drop);
                    m_ovf  = 1;
                end
            end
        end
        m_inr = f;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flit_in = '0;
        ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
    endtask

    task automatic test_reset();
        #1;
        flit_in = mk(1, PORT_ID, 0);
        rst = 1'b1;
        #2;
        n_checks++;
        if (empty !== 1'b1 || dout.valid !== 1'b0 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: empty=%0b valid=%0b occ=%0d, expected 1/0/0", empty, dout.valid, occupancy);
        end
        n_checks++;
        if (drop_cnt !== 0 || misroute_cnt !== 0 || seq_err_cnt !== 0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: drop=%0d mis=%0d seq=%0d ovf=%0b, expected zeros", drop_cnt, misroute_cnt, seq_err_cnt, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        n_checks++;
        if (empty !== 1'b1 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_flit_ignored: empty=%0b occ=%0d, expected 1/0", empty, occupancy);
        end
    endtask

    task automatic test_latency();
        int exp_v[5] = '{0, 1, 1, 1, 0};
        int exp_s[5] = '{0, 0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(i < 3 ? mk(1, PORT_ID, i) : packet_t'('0), 1'b1);
            n_checks++;
            if (dout.valid !== 1'(exp_v[i]) || (exp_v[i] == 1 && int'(dout.seq) != exp_s[i])) begin
                n_fail++;
                $display("FAIL latency_c%0d: valid=%0b seq=%0d, expected valid=%0d seq=%0d", i + 1, dout.valid, dout.seq, exp_v[i], exp_s[i]);
            end
            n_checks++;
            if (dout.valid && dout !== mq[0]) begin
                n_fail++;
                $display("FAIL latency_data_c%0d: got %h expected %h", i + 1, dout, mq[0]);
            end
        end
        n_checks++;
        if (drop_cnt !== 0 || misroute_cnt !== 0 || seq_err_cnt !== 0) begin
            n_fail++;
            $display("FAIL latency_counters: drop=%0d mis=%0d seq=%0d, expected 0", drop_cnt, misroute_cnt, seq_err_cnt);
        end
    endtask

    task automatic test_misroute();
        do_reset();
        cycle(mk(1, 3, 5), 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        n_checks++;
        if (misroute_cnt !== 4'd1 || dout.valid !== 1'b0 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL misroute: cnt=%0d valid=%0b occ=%0d, expected 1/0/0", misroute_cnt, dout.valid, occupancy);
        end
        cycle(mk(1, PORT_ID, 0), 1'b1);
        cycle('0, 1'b1);
        n_checks++;
        if (dout.valid !== 1'b1 || dout.seq !== 8'd0 || seq_err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL misroute_next: valid=%0b seq=%0d seqerr=%0d, expected 1/0/0", dout.valid, dout.seq, seq_err_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(mk(3, PORT_ID, i), 1'b0);
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        n_checks++;
        if (occupancy !== 4'd8 || drop_cnt !== 4'd2 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_fill: occ=%0d drop=%0d ovf=%0b, expected 8/2/1", occupancy, drop_cnt, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dout.valid !== 1'b1 || int'(dout.seq) != i || dout !== mq[0]) begin
                n_fail++;
                $display("FAIL overflow_drain_%0d: valid=%0b seq=%0d, expected 1/%0d", i, dout.valid, dout.seq, i);
            end
            cycle('0, 1'b1);
        end
        n_checks++;
        if (empty !== 1'b1 || dout.valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_empty: empty=%0b valid=%0b ovf=%0b, expected 1/0/1", empty, dout.valid, overflow);
        end
        // Dropped flits still advanced the expectation, so seq 10 is in order.
        cycle(mk(3, PORT_ID, 10), 1'b1);
        cycle('0, 1'b0);
        n_checks++;
        if (seq_err_cnt !== 4'd0 || dout.seq !== 8'd10) begin
            n_fail++;
            $display("FAIL overflow_seq_resume: seqerr=%0d seq=%0d, expected 0/10", seq_err_cnt, dout.seq);
        end
    endtask

    task automatic test_full_bypass();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(mk(0, PORT_ID, i), 1'b0);
        cycle(mk(0, PORT_ID, 8), 1'b0);
        cycle('0, 1'b1);
        n_checks++;
        if (occupancy !== 4'd8 || drop_cnt !== 4'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_bypass: occ=%0d drop=%0d ovf=%0b, expected 8/0/0", occupancy, drop_cnt, overflow);
        end
        n_checks++;
        if (dout.seq !== 8'd1 || mq.size() != 8 || mq[7].seq != 8'd8) begin
            n_fail++;
            $display("FAIL full_bypass_head: seq=%0d, expected 1", dout.seq);
        end
    endtask

    task automatic test_seq_error();
        int sq[4] = '{0, 1, 3, 4};
        int got[$];
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(i < 4 ? mk(0, PORT_ID, sq[i]) : packet_t'('0), 1'b1);
            if (dout.valid) got.push_back(int'(dout.seq));
            n_checks++;
            if (seq_err_cnt !== CNT_W'(m_seq)) begin
                n_fail++;
                $display("FAIL seq_err_c%0d: cnt=%0d expected %0d", i, seq_err_cnt, m_seq);
            end
        end
        n_checks++;
        if (seq_err_cnt !== 4'd1 || got.size() != 4 || got[0] != 0 || got[1] != 1 || got[2] != 3 || got[3] != 4) begin
            n_fail++;
            $display("FAIL seq_err_total: cnt=%0d delivered=%0d, expected 1 and 0,1,3,4", seq_err_cnt, got.size());
        end
    endtask

    task automatic test_reset_midstream();
        int sq[6] = '{0, 1, 2, 3, 7, 8};
        do_reset();
        for (int i = 0; i < 6; i++) cycle(mk(1, PORT_ID, sq[i]), 1'b0);
        n_checks++;
        if (occupancy !== 4'd5 || seq_err_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL midreset_pre: occ=%0d seqerr=%0d, expected 5/1", occupancy, seq_err_cnt);
        end
        flit_in = mk(1, PORT_ID, 9);
        rst = 1'b1;
        #1;
        n_checks++;
        if (empty !== 1'b1 || dout.valid !== 1'b0 || occupancy !== 4'd0 || seq_err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_now: empty=%0b valid=%0b occ=%0d seqerr=%0d, expected 1/0/0/0", empty, dout.valid, occupancy, seq_err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
        cycle(mk(1, PORT_ID, 0), 1'b1);
        cycle('0, 1'b1);
        n_checks++;
        if (dout.valid !== 1'b1 || dout.seq !== 8'd0 || seq_err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_after: valid=%0b seq=%0d seqerr=%0d, expected 1/0/0", dout.valid, dout.seq, seq_err_cnt);
        end
        cycle('0, 1'b1);
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_drain: empty=%0b expected 1", empty);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) cycle(mk(0, 1, 0), 1'b0);
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        n_checks++;
        if (misroute_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL misroute_saturate: cnt=%0d expected 15", misroute_cnt);
        end
    endtask

    task automatic test_random();
        int tx_seq[NUM_PORTS];
        packet_t f;
        bit r;
        int src, dst, sq;
        do_reset();
        for (int i = 0; i < NUM_PORTS; i++) tx_seq[i] = 0;
        for (int c = 0; c < 400; c++) begin
            f = '0;
            if ($urandom_range(99) < 70) begin
                src = $urandom_range(NUM_PORTS - 1);
                dst = ($urandom_range(99) < 80) ? PORT_ID : $urandom_range(NUM_PORTS - 1);
                sq  = tx_seq[src];
                if ($urandom_range(99) < 10) sq = sq + $urandom_range(1, 5);
                if (dst == PORT_ID) tx_seq[src] = (sq + 1) % 256;
                f = mk(src, dst, sq % 256);
            end
            r = (c < 150) ? ($urandom_range(99) < 25) : ($urandom_range(99) < 75);
            cycle(f, r);
            n_checks++;
            if (dout.valid !== (mq.size() != 0) || (mq.size() != 0 && dout !== mq[0])) begin
                n_fail++;
                $display("FAIL rand_dout_c%0d: valid=%0b got %h expected %h", c, dout.valid, dout, mq.size() ? mq[0] : packet_t'('0));
            end
            n_checks++;
            if (int'(occupancy) != mq.size() || empty !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL rand_occ_c%0d: occ=%0d empty=%0b expected %0d", c, occupancy, empty, mq.size());
            end
            n_checks++;
            if (int'(drop_cnt) != m_drop || int'(misroute_cnt) != m_mis || int'(seq_err_cnt) != m_seq || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_cnt_c%0d: drop=%0d mis=%0d seq=%0d ovf=%0b expected %0d/%0d/%0d/%0b",
                         c, drop_cnt, misroute_cnt, seq_err_cnt, overflow, m_drop, m_mis, m_seq, m_ovf);
            end
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_latency();
        test_misroute();
        test_overflow();
        test_full_bypass();
        test_seq_error();
        test_reset_midstream();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
